mx_acc2stream_serializer: RTL and testbench
===========================================

MX_ACC2STREAM_SERIALIZER -- requirements
Module: mx_acc2stream_serializer

Interface
REQ-001 SHALL have parameter InWidth, default 576, meaning accelerator result word width.
REQ-002 SHALL have parameter OutWidth, default 64, meaning streamer beat width; InWidth SHALL be an integer multiple of OutWidth, giving NumBeats = InWidth/OutWidth (9 by default).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port in_data_i, input, InWidth, the accelerator result word.
REQ-006 SHALL have port in_valid_i, input, 1, input word valid.
REQ-007 SHALL have port in_ready_o, output, 1, input word accepted.
REQ-008 SHALL have port out_data_o, output, OutWidth, the current beat.
REQ-009 SHALL have port out_valid_o, output, 1, beat valid.
REQ-010 SHALL have port out_ready_i, input, 1, downstream streamer ready.
REQ-011 SHALL have port out_last_o, output, 1, asserted with the final beat of a word.
REQ-012 SHALL have port busy_o, output, 1, high while a word is held.
REQ-013 SHALL have port stall_cnt_o, output, 32, output back-pressure cycle count.

Function
REQ-014 SHALL implement FSM states IDLE and SEND.
REQ-015 IDLE: in_ready_o=1, out_valid_o=0; on in_valid_i&in_ready_o, capture in_data_i into a holding register, beat_idx<=0, go to SEND.
REQ-016 SEND: out_valid_o=1, out_data_o=hold[beat_idx*OutWidth +: OutWidth] (LSB slice first), out_last_o=(beat_idx==NumBeats-1).
REQ-017 In SEND, beat_idx SHALL increment by 1 on each out_valid_o&out_ready_i; it SHALL hold otherwise, with out_data_o stable.
REQ-018 in_ready_o SHALL be 1 in SEND only while the last beat handshakes (out_last_o&out_ready_i), so back-to-back words lose no cycle.
REQ-019 Last-beat handshake with in_valid_i=1 SHALL capture the new word, reset beat_idx to 0, and stay in SEND; with in_valid_i=0 it SHALL go to IDLE.
REQ-020 Latency SHALL be one cycle from input handshake to first beat valid; a word of NumBeats beats with out_ready_i held high SHALL take exactly NumBeats cycles.
REQ-021 busy_o SHALL equal (state==SEND).
REQ-022 beat_idx width SHALL be clog2(NumBeats), minimum 1; it SHALL never exceed NumBeats-1.

Reset
REQ-023 rst_i high SHALL asynchronously force IDLE, beat_idx=0, hold=0, stall count=0; outputs in_ready_o=1, out_valid_o=0, out_last_o=0, busy_o=0, out_data_o=0, stall_cnt_o=0.
REQ-024 Reset mid-word SHALL discard the held word; no partial beats follow deassertion.

Configuration
REQ-025 With macro MX_SER_STALL_CNT_EN defined, stall_cnt_o SHALL increment each cycle out_valid_o&!out_ready_i, saturating at 32'hFFFF_FFFF; it clears only on reset.
REQ-026 Without MX_SER_STALL_CNT_EN, stall_cnt_o SHALL be constant 0, no counter logic SHALL be instantiated, and the port list SHALL be unchanged.

Structure
REQ-027 Package mx_ser_pkg SHALL hold the state enum (IDLE, SEND), default widths 576/64, and the NumBeats/beat-index-width derivation function.
REQ-028 The stall counter SHALL be sub-module mx_ser_stall_counter, instantiated only under MX_SER_STALL_CNT_EN.
REQ-029 An elaboration-time assertion SHALL fail if InWidth % OutWidth != 0.

Verification
REQ-030 Load word with slice k = 64'h1111_1111_1111_1111*k (k=0..8), out_ready_i=1 -> beats k=0..8 appear on consecutive cycles, out_last_o only on k=8, then IDLE.
REQ-031 Two words offered back-to-back with out_ready_i=1 -> 18 consecutive valid beats, in_ready_o=1 exactly on the 9th beat cycle, no bubble.
REQ-032 out_ready_i low for 5 cycles during beat 3 -> out_data_o holds slice 3 stable; stall_cnt_o=5 with the macro, 0 without it.
REQ-033 rst_i pulsed asynchronously during beat 4 -> all outputs go to reset values immediately; the next word starts at beat 0.
REQ-034 in_valid_i high continuously during SEND beats 0..7 -> in_ready_o=0 and the held word is unchanged until the last-beat handshake.

Source files
------------

// File: rtl/mx_ser_pkg.sv
// Shared types and width helpers for the accelerator-to-stream serializer.
// Holds the FSM state type, default widths and beat-count derivation.
package mx_ser_pkg;

    localparam int unsigned DefInWidth  = 576;
    localparam int unsigned DefOutWidth = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    function automatic int unsigned ser_num_beats(
        input int unsigned in_w,
        input int unsigned out_w
    );
        return in_w / out_w;
    endfunction

    // Beat index is at least one bit wide even for a single-beat word.
    function automatic int unsigned ser_idx_width(
        input int unsigned in_w,
        input int unsigned out_w
    );
        int unsigned n;
        n = in_w / out_w;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mx_ser_stall_counter.sv
// Saturating 32-bit count of output back-pressure cycles.
// Cleared only by reset; built only with MX_SER_STALL_CNT_EN.
module mx_ser_stall_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Increment on each stalled cycle, holding at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mx_acc2stream_serializer.sv
// Splits one wide accelerator word into NumBeats stream beats, LSB first.
// Optional stall counter enabled by macro MX_SER_STALL_CNT_EN.
module mx_acc2stream_serializer
    import mx_ser_pkg::*;
#(
    parameter int unsigned InWidth  = DefInWidth,
    parameter int unsigned OutWidth = DefOutWidth
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [InWidth-1:0]  in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OutWidth-1:0] out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_last_o,
    output logic                busy_o,
    output logic [31:0]         stall_cnt_o
);

    localparam int unsigned NumBeats = ser_num_beats(InWidth, OutWidth);
    localparam int unsigned IdxW     = ser_idx_width(InWidth, OutWidth);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBeats - 1);

    if ((InWidth % OutWidth) != 0) begin : g_width_chk
        $error("InWidth must be a multiple of OutWidth");
    end

    typedef logic [NumBeats-1:0][OutWidth-1:0] hold_t;

    ser_state_e      state_q, state_d;
    logic [IdxW-1:0] beat_q, beat_d;
    hold_t           hold_q, hold_d;

    logic out_hs;
    logic in_hs;

    assign busy_o      = (state_q == SEND);
    assign out_valid_o = busy_o;
    assign out_last_o  = busy_o && (beat_q == LastIdx);
    assign in_ready_o  = !busy_o || (out_last_o && out_ready_i);
    assign out_data_o  = hold_q[beat_q];

    assign out_hs = out_valid_o & out_ready_i;
    assign in_hs  = in_valid_i & in_ready_o;

    // Next-state: capture on input handshake, advance on beat handshake.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    hold_d  = in_data_i;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_hs) begin
                    if (out_last_o) begin
                        beat_d = '0;
                        if (in_hs) begin
                            hold_d = in_data_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + IdxW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // State, beat index and holding register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
        end
    end

`ifdef MX_SER_STALL_CNT_EN
    mx_ser_stall_counter u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (out_valid_o & ~out_ready_i),
        .cnt_o   (stall_cnt_o)
    );
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_mx_acc2stream_serializer.sv
// Self-checking bench for mx_acc2stream_serializer.
// Beat-queue reference model; directed steps with random data.
module tb_mx_acc2stream_serializer;

    localparam int IW = 576;
    localparam int OW = 64;
    localparam int NB = IW / OW;

    typedef struct packed {
        logic          l;
        logic [OW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [31:0]   stall_cnt;

    int          errors = 0;
    int          checks = 0;
    beat_t       q[$];
    logic [31:0] stall_m = '0;

    mx_acc2stream_serializer #(
        .InWidth  (IW),
        .OutWidth (OW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stall();
`ifdef MX_SER_STALL_CNT_EN
        return stall_m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [IW-1:0] rnd_word();
        logic [IW-1:0] w;
        for (int i = 0; i < IW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [IW-1:0] pat_word();
        logic [IW-1:0] w;
        logic [OW-1:0] base;
        base = 64'h1111_1111_1111_1111;
        for (int k = 0; k < NB; k++) w[k*OW +: OW] = base * OW'(k);
        return w;
    endfunction

    task automatic push_word(input logic [IW-1:0] w);
        beat_t b;
        for (int k = 0; k < NB; k++) begin
            b.l = (k == NB - 1);
            b.d = w[k*OW +: OW];
            q.push_back(b);
        end
    endtask

    // One clock: check outputs against the model, then advance it.
    task automatic step();
        logic exp_rdy;
        logic hs_o;
        logic hs_i;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("busy", 64'(busy), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (q.size() > 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_last", 64'(out_last), 64'(q[0].l));
        end else begin
            chk("out_last_idle", 64'(out_last), 64'd0);
        end
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_stall()));
        hs_o = (q.size() > 0) && out_ready;
        hs_i = in_valid && exp_rdy;
        @(posedge clk);
        if (q.size() > 0 && !out_ready && stall_m != '1) stall_m++;
        if (hs_o) void'(q.pop_front());
        if (hs_i) push_word(in_data);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        chk("drain_bound", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [IW-1:0] w1;
        logic [IW-1:0] w2;
        int vc;
        int rdy_at;
        int lc;
        int lpos;

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Pattern word, continuous ready.
        in_data  = pat_word();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lc = 0;
        lpos = -1;
        for (int k = 0; k < NB; k++) begin
            #1;
            chk("pat_beat", out_data, 64'h1111_1111_1111_1111 * k);
            if (out_last) begin
                lc++;
                lpos = k;
            end
            step();
        end
        chk("pat_last_count", 64'(lc), 64'd1);
        chk("pat_last_pos", 64'(lpos), 64'(NB - 1));
        step();

        // Back-to-back words, no bubble.
        w1 = rnd_word();
        w2 = rnd_word();
        in_data  = w1;
        in_valid = 1'b1;
        step();
        in_data = w2;
        vc = 0;
        rdy_at = -1;
        for (int i = 0; i < 2 * NB; i++) begin
            logic r;
            #1;
            if (out_valid) vc++;
            r = in_ready;
            if (r && rdy_at < 0) rdy_at = i;
            step();
            if (r) in_valid = 1'b0;
        end
        chk("b2b_valid_beats", 64'(vc), 64'(2 * NB));
        chk("b2b_ready_beat", 64'(rdy_at), 64'(NB - 1));
        step();

        // Back-pressure on beat 3.
        in_data  = pat_word();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_hold", out_data, 64'h3333_3333_3333_3333);
            step();
        end
        out_ready = 1'b1;
        drain();
`ifdef MX_SER_STALL_CNT_EN
        chk("stall_total", 64'(stall_cnt), 64'd5);
`else
        chk("stall_total", 64'(stall_cnt), 64'd0);
`endif
        step();

        // Async reset during beat 4.
        w1 = rnd_word();
        in_data  = w1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        #1;
        chk("pre_rst_beat4", out_data, w1[4*OW +: OW]);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_last", 64'(out_last), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        q.delete();
        stall_m = '0;
        @(negedge clk);
        rst = 1'b0;
        step();
        w2 = rnd_word();
        in_data  = w2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("post_rst_beat0", out_data, w2[OW-1:0]);
        drain();
        step();

        // in_valid held through a word.
        w1 = rnd_word();
        w2 = rnd_word();
        in_data  = w1;
        in_valid = 1'b1;
        step();
        in_data = w2;
        for (int i = 0; i < NB - 1; i++) begin
            #1;
            chk("hold_no_ready", 64'(in_ready), 64'd0);
            chk("hold_word", out_data, w1[i*OW +: OW]);
            step();
        end
        step();
        in_valid = 1'b0;
        #1;
        chk("hold_new_beat0", out_data, w2[OW-1:0]);
        drain();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
